// File: rtl/wr_resp_queue.sv
// -----------------------------------------------------------------------------
// wr_resp_queue
//
// Per-direction write-response buffer. The upstream decoder raises a
// single-cycle push strobe with no backpressure; this block captures each
// response into a DEPTH-entry FIFO and hands it to the requesting master over
// a valid/ready handshake. Occupancy and almost-full status let upstream
// admission control throttle new write requests before the queue overflows.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (wins over push/pop)
//   in_vld       push strobe from the decoder (no ready returned)
//   in_pld       response payload {txnid, sideband}
//   out_vld      head entry valid toward the master
//   out_rdy      master accepts the head entry
//   out_pld      head entry payload (combinational read of registered array)
//   count        current occupancy, 0..DEPTH
//   almost_full  free entries <= AFULL_THRESH
//   overflow     sticky: a push was dropped because the queue was full
//
// The file also carries the shared payload package and a simulation-only
// checker module that the top instantiates.
// -----------------------------------------------------------------------------

package vector_cache_pkg;
    localparam int TXNID_W    = 6;
    localparam int SIDEBAND_W = 4;

    typedef struct packed {
        logic [TXNID_W-1:0]    txnid;
        logic [SIDEBAND_W-1:0] sideband;
    } wr_resp_pld_t;
endpackage : vector_cache_pkg

// -----------------------------------------------------------------------------
// wr_resp_queue_chk
//
// Simulation-only property checker for wr_resp_queue. Purely observational:
// every port is an input. Synthesis tools drop concurrent assertions, so
// instantiating it in the top costs no hardware.
// -----------------------------------------------------------------------------
module wr_resp_queue_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4,
    parameter int PLD_W = 10
) (
    input logic             clk,
    input logic             rst,
    input logic             in_vld,
    input logic             out_rdy,
    input logic             out_vld,
    input logic [PLD_W-1:0] out_pld,
    input logic [CNT_W-1:0] count,
    input logic             overflow
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Handshake inputs must be driven to known values once out of reset.
    a_no_x_inputs: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({in_vld, out_rdy}));

    // Occupancy can never exceed the number of physical entries.
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_C);

    // A stalled head entry must hold both its valid and its payload.
    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_vld && !out_rdy) |=> (out_vld && $stable(out_pld)));

    // Valid is exactly "not empty".
    a_vld_matches_count: assert property (@(posedge clk) disable iff (rst)
        out_vld == (count != {CNT_W{1'b0}}));

    // Overflow is sticky until reset.
    a_overflow_sticky: assert property (@(posedge clk) disable iff (rst)
        overflow |=> overflow);
endmodule : wr_resp_queue_chk

// -----------------------------------------------------------------------------
// wr_resp_queue top
// -----------------------------------------------------------------------------
module wr_resp_queue
    import vector_cache_pkg::*;
#(
    parameter  int DEPTH        = 8,
    parameter  int AFULL_THRESH = 2,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  wr_resp_pld_t     in_pld,
    output logic             out_vld,
    input  logic             out_rdy,
    output wr_resp_pld_t     out_pld,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int PLD_W = $bits(wr_resp_pld_t);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Storage and state
    wr_resp_pld_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             out_vld_r;
    logic             almost_full_r;
    logic             overflow_r;

    // Per-cycle decisions
    logic             pop_s;
    logic             full_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Handshake decode: a full queue still accepts a push when the head leaves
    // in the same cycle, because the freed slot is reused.
    always_comb begin
        pop_s     = out_vld_r & out_rdy;
        full_s    = (count_r == DEPTH_C);
        push_ok_s = in_vld & (~full_s | pop_s);
        drop_s    = in_vld & ~push_ok_s;
    end

    // Next occupancy from the accepted push and the pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            2'b11:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry array: cleared on reset so an empty queue never presents unknown
    // data; otherwise written at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= in_pld;
        end
    end

    // Pointers, occupancy and status flags. out_vld and almost_full are
    // registered from the next occupancy, which makes them identical to a
    // combinational decode of count while keeping the outputs glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= CNT_ZERO;
            out_vld_r     <= 1'b0;
            almost_full_r <= (DEPTH_C <= THRESH_C);
            overflow_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_nxt_s;
            out_vld_r     <= (count_nxt_s != CNT_ZERO);
            almost_full_r <= ((DEPTH_C - count_nxt_s) <= THRESH_C);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output drive: head payload is a direct read of the registered array.
    always_comb begin
        out_pld     = mem_r[rd_ptr_r];
        out_vld     = out_vld_r;
        count       = count_r;
        almost_full = almost_full_r;
        overflow    = overflow_r;
    end

    wr_resp_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PLD_W (PLD_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld_r),
        .out_pld  (out_pld),
        .count    (count_r),
        .overflow (overflow_r)
    );
endmodule : wr_resp_queue
